param_entry: RTL and testbench
==============================

PARAM_ENTRY -- requirements
Module: param_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable cycles required before a key level is accepted (10 ms at 50 MHz).
REQ-002 Parameter MAX_VAL, default 99, largest value any field holds (two-digit display limit).
REQ-003 CLOCK_50  input  1  system clock; sole clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 KEY0  input  1  increment key, active-low, asynchronous pushbutton.
REQ-006 KEY1  input  1  decrement key, active-low, asynchronous.
REQ-007 KEY2  input  1  field-select key, active-low, asynchronous.
REQ-008 KEY3  input  1  load key, active-low, asynchronous.
REQ-009 SW  input  7  value loaded into the selected field on a KEY3 press.
REQ-010 seq_num  output  7  sequence-number field.
REQ-011 freq_num  output  7  frequency-number field.
REQ-012 rom_addr  output  7  ROM-address field.
REQ-013 disp_val  output  7  value of the currently selected field, for the two-digit BCD display.
REQ-014 LEDR  output  10 (0:9)  LEDR[0..2] one-hot selected field (SEQ, FREQ, ADDR); LEDR[3..9] 0.

Function
REQ-015 Each KEY shall pass through a 2-flop synchronizer reset to 1 (released).
REQ-016 The debouncer shall count consecutive cycles in which the synchronized level differs from the accepted level, clear the count whenever the levels match, and adopt the new level when the count reaches DEBOUNCE_CYCLES.
REQ-017 A press event shall be a one-cycle pulse on an accepted 1->0 transition; releases generate no event.
REQ-018 Field selector FSM states SEQ, FREQ, ADDR; a KEY2 press shall advance SEQ->FREQ->ADDR->SEQ.
REQ-019 A KEY0 press shall increment the selected field; MAX_VAL wraps to 0.
REQ-020 A KEY1 press shall decrement the selected field; 0 wraps to MAX_VAL.
REQ-021 A KEY3 press shall load SW into the selected field, saturating to MAX_VAL when SW > MAX_VAL.
REQ-022 When several press events occur in the same cycle, only the highest-priority one (KEY3 > KEY2 > KEY0 > KEY1) shall act; the rest are discarded.
REQ-023 Non-selected fields shall hold their values on every event.
REQ-024 All outputs shall be registered; a field update shall be visible on outputs exactly one cycle after its press pulse.
REQ-025 End-to-end latency from a pin transition to the output update shall be DEBOUNCE_CYCLES+4 cycles ±1.
REQ-026 Bounce shorter than DEBOUNCE_CYCLES cycles shall produce no event.
REQ-027 disp_val and LEDR shall follow the selector in the same cycle as the field registers change.

Reset
REQ-028 While reset is high: all fields 0, selector SEQ, disp_val 0, LEDR = 10'b1000000000 (bit 0 set), debounce counters 0, accepted levels 1, no press pulses.
REQ-029 Reset asserted mid-debounce shall discard the pending transition.
REQ-030 A key held low across reset deassertion shall yield exactly one press event after DEBOUNCE_CYCLES.

Structure
REQ-031 Package param_entry_pkg shall hold the field enum (SEQ, FREQ, ADDR), FIELD_W = 7, and MAX_VAL default.
REQ-032 Sub-module key_debounce (synchronizer, debounce counter, press pulse) shall be instantiated four times; the field FSM and registers stay in param_entry.

Verification (DEBOUNCE_CYCLES = 4)
REQ-033 Reset, KEY0 pressed 5 times cleanly -> seq_num = 5, disp_val = 5, LEDR[0] = 1.
REQ-034 KEY2 once, then KEY1 once -> freq_num = 99, seq_num unchanged, LEDR[1] = 1.
REQ-035 Select ADDR, SW = 120, KEY3 -> rom_addr = 99; SW = 42, KEY3 -> rom_addr = 42.
REQ-036 KEY0 toggling every 2 cycles for 20 cycles, then released -> no field change.
REQ-037 KEY3 and KEY0 reach the accepted pressed level in the same cycle with SW = 7 -> selected field = 7, not 8.
REQ-038 Reset pulsed mid-debounce of KEY0 (key then released) -> all fields 0, no increment after reset.

Source files
------------

// File: rtl/param_entry_pkg.sv
// Shared types and constants for the parameter-entry panel: field selector
// encoding, field width and the default two-digit value limit.
package param_entry_pkg;

  localparam int unsigned FIELD_W         = 7;
  localparam int unsigned MAX_VAL_DEFAULT = 99;

  typedef enum logic [1:0] {
    SEQ,
    FREQ,
    ADDR
  } field_e;

  function automatic field_e next_field(input field_e f);
    case (f)
      SEQ:     return FREQ;
      FREQ:    return ADDR;
      default: return SEQ;
    endcase
  endfunction

endpackage

// File: rtl/param_entry_if.sv
// Pin-level bundle of the parameter-entry panel: four active-low keys and the
// switch bank in, the three fields plus display/LED state out.
interface param_entry_if;
  import param_entry_pkg::*;

  logic               key0;
  logic               key1;
  logic               key2;
  logic               key3;
  logic [FIELD_W-1:0] sw;
  logic [FIELD_W-1:0] seq_num;
  logic [FIELD_W-1:0] freq_num;
  logic [FIELD_W-1:0] rom_addr;
  logic [FIELD_W-1:0] disp_val;
  logic [0:9]         ledr;

  modport master (
    output key0, key1, key2, key3, sw,
    input  seq_num, freq_num, rom_addr, disp_val, ledr
  );

  modport slave (
    input  key0, key1, key2, key3, sw,
    output seq_num, freq_num, rom_addr, disp_val, ledr
  );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton channel: 2-flop synchronizer, consecutive-mismatch debounce
// counter and a single-cycle pulse on each accepted press (1->0).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive mismatching sample.
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/param_entry.sv
// Three-field parameter entry: debounced keys step, select and load the
// SEQ/FREQ/ADDR fields; the selected field drives the display and LEDs.
module param_entry
  import param_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_VAL         = MAX_VAL_DEFAULT
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               KEY0,
  input  logic               KEY1,
  input  logic               KEY2,
  input  logic               KEY3,
  input  logic [FIELD_W-1:0] SW,
  output logic [FIELD_W-1:0] seq_num,
  output logic [FIELD_W-1:0] freq_num,
  output logic [FIELD_W-1:0] rom_addr,
  output logic [FIELD_W-1:0] disp_val,
  output logic [0:9]         LEDR
);

  localparam logic [FIELD_W-1:0] MAX_F = FIELD_W'(MAX_VAL);

  logic [3:0]         press;
  field_e             sel;
  field_e             sel_nxt;
  logic [FIELD_W-1:0] cur;
  logic [FIELD_W-1:0] upd;
  logic               write;
  logic [FIELD_W-1:0] seq_nxt;
  logic [FIELD_W-1:0] freq_nxt;
  logic [FIELD_W-1:0] addr_nxt;
  logic [FIELD_W-1:0] disp_nxt;
  logic [0:9]         led_nxt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk(CLOCK_50), .rst(reset), .key_n(KEY0), .press(press[0]));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk(CLOCK_50), .rst(reset), .key_n(KEY1), .press(press[1]));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
    .clk(CLOCK_50), .rst(reset), .key_n(KEY2), .press(press[2]));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key3 (
    .clk(CLOCK_50), .rst(reset), .key_n(KEY3), .press(press[3]));

  always_comb begin
    case (sel)
      SEQ:     cur = seq_num;
      FREQ:    cur = freq_num;
      default: cur = rom_addr;
    endcase

    upd     = cur;
    write   = 1'b0;
    sel_nxt = sel;
    // Priority KEY3 > KEY2 > KEY0 > KEY1; lower-priority events are dropped.
    if (press[3]) begin
      upd   = (SW > MAX_F) ? MAX_F : SW;
      write = 1'b1;
    end else if (press[2]) begin
      sel_nxt = next_field(sel);
    end else if (press[0]) begin
      upd   = (cur >= MAX_F) ? '0 : cur + FIELD_W'(1);
      write = 1'b1;
    end else if (press[1]) begin
      upd   = (cur == '0) ? MAX_F : cur - FIELD_W'(1);
      write = 1'b1;
    end

    seq_nxt  = (write && sel == SEQ)  ? upd : seq_num;
    freq_nxt = (write && sel == FREQ) ? upd : freq_num;
    addr_nxt = (write && sel == ADDR) ? upd : rom_addr;

    // Display and LEDs are derived from next-state so they move with the fields.
    led_nxt = '0;
    case (sel_nxt)
      SEQ: begin
        disp_nxt   = seq_nxt;
        led_nxt[0] = 1'b1;
      end
      FREQ: begin
        disp_nxt   = freq_nxt;
        led_nxt[1] = 1'b1;
      end
      default: begin
        disp_nxt   = addr_nxt;
        led_nxt[2] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sel      <= SEQ;
      seq_num  <= '0;
      freq_num <= '0;
      rom_addr <= '0;
      disp_val <= '0;
      LEDR     <= 10'b1000000000;
    end else begin
      sel      <= sel_nxt;
      seq_num  <= seq_nxt;
      freq_num <= freq_nxt;
      rom_addr <= addr_nxt;
      disp_val <= disp_nxt;
      LEDR     <= led_nxt;
    end
  end

endmodule

// File: tb/tb_param_entry.sv
// Self-checking bench for param_entry: directed scenarios plus random key
// activity, compared every cycle against a sample-window behavioural model.
module tb_param_entry;

  localparam int unsigned D    = 4;
  localparam int unsigned MAXV = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;

  param_entry_if bus();

  always #5 clk = ~clk;

  param_entry #(.DEBOUNCE_CYCLES(D), .MAX_VAL(MAXV)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .KEY0     (bus.key0),
    .KEY1     (bus.key1),
    .KEY2     (bus.key2),
    .KEY3     (bus.key3),
    .SW       (bus.sw),
    .seq_num  (bus.seq_num),
    .freq_num (bus.freq_num),
    .rom_addr (bus.rom_addr),
    .disp_val (bus.disp_val),
    .LEDR     (bus.ledr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a key's level is accepted once its last D synchronized
  // samples (two cycles old) all differ from the accepted level.
  int unsigned m_fld [3];
  int unsigned m_sel;
  bit          m_pr  [4];
  bit          m_acc [4];
  bit          m_hist[4][D+2];
  bit          started = 1'b0;

  initial begin
    logic [3:0] pins;
    bit         stable;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 3; i++) m_fld[i] = 0;
        m_sel = 0;
        for (int k = 0; k < 4; k++) begin
          m_pr[k]  = 1'b0;
          m_acc[k] = 1'b1;
          for (int j = 0; j < D + 2; j++) m_hist[k][j] = 1'b1;
        end
        started = 1'b1;
      end else begin
        if (m_pr[3])      m_fld[m_sel] = (int'(bus.sw) > MAXV) ? MAXV : int'(bus.sw);
        else if (m_pr[2]) m_sel = (m_sel + 1) % 3;
        else if (m_pr[0]) m_fld[m_sel] = (m_fld[m_sel] + 1) % (MAXV + 1);
        else if (m_pr[1]) m_fld[m_sel] = (m_fld[m_sel] + MAXV) % (MAXV + 1);
        pins = {bus.key3, bus.key2, bus.key1, bus.key0};
        for (int k = 0; k < 4; k++) begin
          for (int j = D + 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
          m_hist[k][0] = pins[k];
          stable = 1'b1;
          for (int j = 2; j <= D + 1; j++)
            if (m_hist[k][j] == m_acc[k]) stable = 1'b0;
          m_pr[k] = 1'b0;
          if (stable) begin
            m_acc[k] = ~m_acc[k];
            m_pr[k]  = (m_acc[k] == 1'b0);
          end
        end
      end
    end
  end

  initial begin
    logic [0:9] e_led;
    forever begin
      @(negedge clk);
      if (started) begin
        e_led = 10'b1000000000 >> m_sel;
        check("seq_num",  32'(bus.seq_num),  m_fld[0]);
        check("freq_num", 32'(bus.freq_num), m_fld[1]);
        check("rom_addr", 32'(bus.rom_addr), m_fld[2]);
        check("disp_val", 32'(bus.disp_val), m_fld[m_sel]);
        check("ledr",     32'(bus.ledr),     32'(e_led));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_keys(input logic [3:0] lvl);
    bus.key0 = lvl[0];
    bus.key1 = lvl[1];
    bus.key2 = lvl[2];
    bus.key3 = lvl[3];
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    set_keys(~mask);
    tick(hold);
    set_keys(4'hF);
    tick(D + 6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] mask;
    set_keys(4'hF);
    bus.sw = '0;
    rst    = 1'b1;
    tick(3);
    check("rst_seq",  32'(bus.seq_num), 0);
    check("rst_disp", 32'(bus.disp_val), 0);
    check("rst_ledr", 32'(bus.ledr), 32'h200);
    rst = 1'b0;
    tick(1);

    repeat (5) press(4'b0001, D + 2);
    check("inc5_seq",  32'(bus.seq_num), 5);
    check("inc5_disp", 32'(bus.disp_val), 5);
    check("inc5_led0", 32'(bus.ledr[0]), 1);
    check("model_inc5", m_fld[0], 5);

    press(4'b0100, D + 2);
    press(4'b0010, D + 2);
    check("dec_wrap_freq", 32'(bus.freq_num), 99);
    check("dec_hold_seq",  32'(bus.seq_num), 5);
    check("dec_led1",      32'(bus.ledr[1]), 1);
    check("model_freq99",  m_fld[1], 99);
    press(4'b0001, D + 2);
    check("inc_wrap_freq", 32'(bus.freq_num), 0);
    press(4'b0010, D + 2);
    check("dec_again_freq", 32'(bus.freq_num), 99);

    press(4'b0100, D + 2);
    bus.sw = 7'd120;
    press(4'b1000, D + 2);
    check("load_sat_addr", 32'(bus.rom_addr), 99);
    bus.sw = 7'd42;
    press(4'b1000, D + 2);
    check("load_addr", 32'(bus.rom_addr), 42);
    check("load_led2", 32'(bus.ledr[2]), 1);

    repeat (5) begin
      bus.key0 = 1'b0;
      tick(2);
      bus.key0 = 1'b1;
      tick(2);
    end
    tick(D + 6);
    check("bounce_addr", 32'(bus.rom_addr), 42);
    check("bounce_seq",  32'(bus.seq_num), 5);

    bus.sw = 7'd7;
    press(4'b1001, D + 2);
    check("prio_addr", 32'(bus.rom_addr), 7);
    check("model_prio", m_fld[2], 7);

    set_keys(4'b1110);
    tick(2);
    rst = 1'b1;
    set_keys(4'hF);
    tick(2);
    rst = 1'b0;
    tick(D + 6);
    check("midrst_seq",  32'(bus.seq_num), 0);
    check("midrst_freq", 32'(bus.freq_num), 0);
    check("midrst_addr", 32'(bus.rom_addr), 0);

    bus.key0 = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(D + 4);
    bus.key0 = 1'b1;
    tick(D + 6);
    check("held_rst_seq", 32'(bus.seq_num), 1);

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      bus.sw = 7'($urandom_range(0, 127));
      if (r == 0) begin
        mask = 4'b0001 << $urandom_range(0, 3);
        set_keys(~mask);
        tick($urandom_range(0, 5));
        rst = 1'b1;
        if ($urandom_range(0, 1) == 1) set_keys(4'hF);
        tick($urandom_range(1, 3));
        rst = 1'b0;
        tick($urandom_range(0, D + 4));
        set_keys(4'hF);
        tick(D + 6);
      end else if (r == 1) begin
        mask = 4'b0001 << $urandom_range(0, 3);
        repeat ($urandom_range(2, 6)) begin
          set_keys(~mask);
          tick($urandom_range(1, D - 1));
          set_keys(4'hF);
          tick($urandom_range(1, D - 1));
        end
        tick(D + 6);
      end else begin
        if ($urandom_range(0, 4) == 0) mask = 4'($urandom_range(1, 15));
        else mask = 4'b0001 << $urandom_range(0, 3);
        press(mask, $urandom_range(D - 1, D + 6));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
